swap_hazard_sequencer: RTL

//  Pipeline sequencer in ID stage beside the control unit. Detects RAW hazards against the EXE/MEM destinations
//  and stalls the front end. Sequences the two-cycle SWP instruction (opcode 6'b111111) through a state machine.

---
 rtl/swap_hazard_sequencer_pkg.sv | 23 ++
 rtl/swap_hazard_sequencer_if.sv | 38 +++
 rtl/swap_hazard_sequencer_raw.sv | 34 +++
 rtl/swap_hazard_sequencer.sv | 114 +++++++++++
 4 files changed

// File: rtl/swap_hazard_sequencer_pkg.sv
// Shared constants and types for the ID-stage swap/hazard sequencer.
package swap_hazard_sequencer_pkg;

  // Opcodes seen in ID
  localparam logic [5:0] OP_SWP   = 6'b111111;
  localparam logic [5:0] OP_NOP   = 6'b000000;

  // exec_cmd overrides issued while SWP is sequenced
  localparam logic [3:0] EXE_NONE = 4'b0000;
  localparam logic [3:0] EXE_SWP1 = 4'b1100;
  localparam logic [3:0] EXE_SWP2 = 4'b1101;

  // swp_sel encodings
  localparam logic [1:0] SEL_NONE = 2'b00;
  localparam logic [1:0] SEL_SWP1 = 2'b01;
  localparam logic [1:0] SEL_SWP2 = 2'b10;

  typedef enum logic {
    IDLE = 1'b0,
    SWP2 = 1'b1
  } seq_state_e;

endpackage

// File: rtl/swap_hazard_sequencer_if.sv
// ID-stage operand/destination inputs and pipeline control outputs.
interface swap_hazard_sequencer_if #(
  parameter int REG_AW = 5,
  parameter int CNT_W  = 16
);
  logic [5:0]        opcode_id;
  logic [REG_AW-1:0] src1_id;
  logic [REG_AW-1:0] src2_id;
  logic              single_src_id;
  logic [REG_AW-1:0] exe_dest;
  logic              exe_wb_en;
  logic              exe_mem_r_en;
  logic [REG_AW-1:0] mem_dest;
  logic              mem_wb_en;
  logic              branch_taken;
  logic              freeze;
  logic              bubble;
  logic              flush;
  logic [1:0]        swp_sel;
  logic              swp_cmd_vld;
  logic [3:0]        swp_cmd;
  logic [CNT_W-1:0]  stall_cnt;
  logic [CNT_W-1:0]  swap_cnt;

  // Pipeline side: drives ID/EXE/MEM state, consumes control
  modport master (
    output opcode_id, src1_id, src2_id, single_src_id,
           exe_dest, exe_wb_en, exe_mem_r_en, mem_dest, mem_wb_en, branch_taken,
    input  freeze, bubble, flush, swp_sel, swp_cmd_vld, swp_cmd, stall_cnt, swap_cnt
  );

  // Sequencer side
  modport slave (
    input  opcode_id, src1_id, src2_id, single_src_id,
           exe_dest, exe_wb_en, exe_mem_r_en, mem_dest, mem_wb_en, branch_taken,
    output freeze, bubble, flush, swp_sel, swp_cmd_vld, swp_cmd, stall_cnt, swap_cnt
  );
endinterface

// File: rtl/swap_hazard_sequencer_raw.sv
// Combinational RAW hazard detect of ID sources against EXE/MEM destinations.
module raw_hazard_detect #(
  parameter bit FORWARDING_EN = 1'b0,
  parameter int REG_AW        = 5
) (
  input  logic [REG_AW-1:0] src1,
  input  logic [REG_AW-1:0] src2,
  input  logic              single_src,
  input  logic [REG_AW-1:0] exe_dest,
  input  logic              exe_wb_en,
  input  logic              exe_mem_r_en,
  input  logic [REG_AW-1:0] mem_dest,
  input  logic              mem_wb_en,
  output logic              hazard
);

  logic hit1, hit2;

  // r0 is hardwired zero, so it can never carry a dependency.
  // With forwarding only a load in EXE cannot be bypassed in time.
  always_comb begin
    if (FORWARDING_EN) begin
      hit1 = (src1 != '0) && exe_mem_r_en && exe_wb_en && (src1 == exe_dest);
      hit2 = (src2 != '0) && exe_mem_r_en && exe_wb_en && (src2 == exe_dest);
    end else begin
      hit1 = (src1 != '0) && ((exe_wb_en && (src1 == exe_dest)) ||
                              (mem_wb_en && (src1 == mem_dest)));
      hit2 = (src2 != '0) && ((exe_wb_en && (src2 == exe_dest)) ||
                              (mem_wb_en && (src2 == mem_dest)));
    end
    hazard = hit1 || (hit2 && !single_src);
  end

endmodule

// File: rtl/swap_hazard_sequencer.sv
// ID-stage sequencer: RAW stall, two-cycle SWP sequencing, branch flush,
// saturating stall/swap performance counters.
module swap_hazard_sequencer
  import swap_hazard_sequencer_pkg::*;
#(
  parameter bit FORWARDING_EN = 1'b0,
  parameter int REG_AW        = 5,
  parameter int CNT_W         = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  swap_hazard_sequencer_if.slave  bus
);

  seq_state_e       state_q, state_d;
  logic             hazard;
  logic             stall_inc, swap_inc;
  logic [CNT_W-1:0] stall_q, swap_q;

  logic             freeze, bubble, flush, swp_cmd_vld;
  logic [1:0]       swp_sel;
  logic [3:0]       swp_cmd;

  raw_hazard_detect #(
    .FORWARDING_EN (FORWARDING_EN),
    .REG_AW        (REG_AW)
  ) u_raw (
    .src1         (bus.src1_id),
    .src2         (bus.src2_id),
    .single_src   (bus.single_src_id),
    .exe_dest     (bus.exe_dest),
    .exe_wb_en    (bus.exe_wb_en),
    .exe_mem_r_en (bus.exe_mem_r_en),
    .mem_dest     (bus.mem_dest),
    .mem_wb_en    (bus.mem_wb_en),
    .hazard       (hazard)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next state and control; Mealy in IDLE, Moore in SWP2 except the branch
  // override (the older branch in EXE kills the SWP still in ID).
  // Outputs are gated by rst_n so reset silences them without waiting for a clock.
  always_comb begin
    state_d     = IDLE;
    freeze      = 1'b0;
    bubble      = 1'b0;
    flush       = 1'b0;
    swp_sel     = SEL_NONE;
    swp_cmd_vld = 1'b0;
    swp_cmd     = EXE_NONE;
    stall_inc   = 1'b0;
    swap_inc    = 1'b0;
    if (rst_n) begin
      unique case (state_q)
        IDLE: begin
          if (bus.branch_taken) begin
            flush  = 1'b1;
            bubble = 1'b1;
          end else if (hazard) begin
            freeze    = 1'b1;
            bubble    = 1'b1;
            stall_inc = 1'b1;
          end else if (bus.opcode_id == OP_SWP) begin
            // freeze keeps SWP in ID for its second phase
            freeze      = 1'b1;
            swp_sel     = SEL_SWP1;
            swp_cmd_vld = 1'b1;
            swp_cmd     = EXE_SWP1;
            state_d     = SWP2;
          end
        end
        SWP2: begin
          // operands were hazard-checked on entry; hazard is ignored here
          if (bus.branch_taken) begin
            flush  = 1'b1;
            bubble = 1'b1;
          end else begin
            swp_sel     = SEL_SWP2;
            swp_cmd_vld = 1'b1;
            swp_cmd     = EXE_SWP2;
            swap_inc    = 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Saturating performance counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_q <= '0;
      swap_q  <= '0;
    end else begin
      if (stall_inc && (stall_q != '1)) stall_q <= stall_q + CNT_W'(1);
      if (swap_inc  && (swap_q  != '1)) swap_q  <= swap_q  + CNT_W'(1);
    end
  end

  assign bus.freeze      = freeze;
  assign bus.bubble      = bubble;
  assign bus.flush       = flush;
  assign bus.swp_sel     = swp_sel;
  assign bus.swp_cmd_vld = swp_cmd_vld;
  assign bus.swp_cmd     = swp_cmd;
  assign bus.stall_cnt   = stall_q;
  assign bus.swap_cnt    = swap_q;

endmodule
